// File: rtl/seq_gen.sv
// seq_gen: serial bit-sequence generator (transmit side of the sequence detector).
// It accepts a pattern, a length and a repeat count over a valid/ready handshake.
// It then sends the pattern MSB-first, one bit per clock, rep_in+1 times.
// GAP idle cycles are inserted between repeats.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start_vld  request valid; pat_in/len_in/rep_in sampled on accept
//   start_rdy  high while idle (combinational from state)
//   pat_in     pattern; bit [len_in-1] is sent first
//   len_in     pattern length, clamped to MAX_LEN; 0 = empty job
//   rep_in     extra repeats
//   dout       serial data bit, 0 when dout_vld=0
//   dout_vld   dout carries a pattern bit
//   busy       job in progress, from accept through the done cycle
//   done       one-cycle pulse after the final bit
module seq_gen #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int REP_W   = 4,
    parameter int GAP     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_vld,
    output logic               start_rdy,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic [REP_W-1:0]   rep_in,
    output logic               dout,
    output logic               dout_vld,
    output logic               busy,
    output logic               done
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP_W, DONE} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               dout_q, dout_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    assign start_rdy = (state_q == IDLE);
    assign dout      = dout_q;
    assign dout_vld  = vld_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        pat_d     = pat_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        rep_d     = rep_q;
        gap_d     = gap_q;

        unique case (state_q)
            IDLE: begin
                if (start_vld) begin
                    len_d     = (len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_in;
                    // Pattern is stored MSB-aligned so the first bit is always sr[MAX_LEN-1].
                    pat_d     = pat_in << (LEN_W'(MAX_LEN) - len_d);
                    sr_d      = pat_d;
                    rep_d     = rep_in;
                    bit_cnt_d = len_d;
                    state_d   = (len_d != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                sr_d = sr_q << 1;
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
                // <=1 rather than ==1 so a corrupted zero count cannot strand the FSM.
                if (bit_cnt_q <= LEN_W'(1)) begin
                    if (rep_q == '0) begin
                        state_d = DONE;
                    end else begin
                        rep_d     = rep_q - 1'b1;
                        sr_d      = pat_q;
                        bit_cnt_d = len_q;
                        if (GAP > 0) begin
                            state_d = GAP_W;
                            gap_d   = GW'(GAP);
                        end
                    end
                end
            end
            GAP_W: begin
                if (gap_q <= GW'(1)) begin
                    state_d = SHIFT;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: they are decoded from the state being entered.
        vld_d  = (state_d == SHIFT);
        dout_d = (state_d == SHIFT) & sr_d[MAX_LEN-1];
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            dout_q    <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Testbench for seq_gen. It uses two instances, one with GAP=0 and one with GAP=2.
// Each accepted request pushes its expected per-cycle response into a queue.
// A per-instance monitor pops one entry per busy cycle and compares it.
module tb_seq_gen;

    logic        clk, rst;
    logic        vld0, vld1;
    logic        rdy0, rdy1;
    logic [15:0] pat_in;
    logic [4:0]  len_in;
    logic [3:0]  rep_in;
    logic        dout0, dv0, busy0, done0;
    logic        dout1, dv1, busy1, done1;

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;

    // Expected cycle codes: 0/1 = data bit, 2 = done cycle, 3 = idle gap cycle
    int q0[$];
    int q1[$];

    // Loopback detector model on instance 0 (target 1011)
    logic [3:0] hist;
    int hit_cnt, first_hit, bit_idx;

    seq_gen #(.MAX_LEN(16), .LEN_W(5), .REP_W(4), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start_vld(vld0), .start_rdy(rdy0),
        .pat_in(pat_in), .len_in(len_in), .rep_in(rep_in),
        .dout(dout0), .dout_vld(dv0), .busy(busy0), .done(done0)
    );

    seq_gen #(.MAX_LEN(16), .LEN_W(5), .REP_W(4), .GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .start_vld(vld1), .start_rdy(rdy1),
        .pat_in(pat_in), .len_in(len_in), .rep_in(rep_in),
        .dout(dout1), .dout_vld(dv1), .busy(busy1), .done(done1)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Reference model: the job expressed as a list of cycles
    task automatic push_model(input int d, input logic [15:0] pat, input int len, input int rep);
        int l, g;
        l = (len > 16) ? 16 : len;
        g = (d == 0) ? 0 : 2;
        for (int r = 0; r <= rep; r++) begin
            if (l > 0) begin
                for (int i = l - 1; i >= 0; i--) begin
                    if (d == 0) q0.push_back(int'(pat[i])); else q1.push_back(int'(pat[i]));
                end
                if (r < rep) begin
                    for (int k = 0; k < g; k++) begin
                        if (d == 0) q0.push_back(3); else q1.push_back(3);
                    end
                end
            end
        end
        if (d == 0) q0.push_back(2); else q1.push_back(2);
    endtask

    task automatic mon(input int d, input logic b, input logic v, input logic o, input logic dn);
        int e, sz;
        logic [2:0] act, exp_t;
        act = {dn, v, o};
        sz  = (d == 0) ? q0.size() : q1.size();
        if (b) begin
            if (sz == 0) begin
                checks++;
                errors++;
                $display("FAIL mon%0d_unexpected: busy with {done,vld,dout}=%b, expected no activity", d, act);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                exp_t = (e == 2) ? 3'b100 : (e == 3) ? 3'b000 : {2'b01, e[0]};
                check($sformatf("mon%0d_cycle", d), {29'd0, act}, {29'd0, exp_t});
            end
        end else begin
            check($sformatf("mon%0d_idle", d), {29'd0, act}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, busy0, dv0, dout0, done0);
            mon(1, busy1, dv1, dout1, done1);
            if (dv0) begin
                if ({hist[2:0], dout0} == 4'b1011) begin
                    hit_cnt++;
                    if (first_hit < 0) first_hit = bit_idx;
                end
                hist = {hist[2:0], dout0};
                bit_idx++;
            end
        end
    end

    // Issues a request and returns at #1 after the accept edge.
    task automatic issue(input int d, input logic [15:0] pat, input int len, input int rep);
        int n;
        n = 0;
        pat_in = pat;
        len_in = 5'(len);
        rep_in = 4'(rep);
        if (d == 0) vld0 = 1'b1; else vld1 = 1'b1;
        while (((d == 0) ? rdy0 : rdy1) !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout%0d: start_rdy=0 after %0d cycles, expected 1", d, n);
                vld0 = 1'b0;
                vld1 = 1'b0;
                return;
            end
        end
        push_model(d, pat, len, rep);
        @(posedge clk);
        #1;
        if (d == 0) vld0 = 1'b0; else vld1 = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while ((d == 0) ? (q0.size() != 0 || busy0) : (q1.size() != 0 || busy1)) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout%0d: job still pending after %0d cycles, expected finish", d, n);
                return;
            end
        end
    endtask

    initial begin
        logic [15:0] p;
        int d, l, r;
        rst = 1;
        vld0 = 0;
        vld1 = 0;
        pat_in = '0;
        len_in = '0;
        rep_in = '0;
        hist = '0;
        hit_cnt = 0;
        first_hit = -1;
        bit_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check("reset_outs0", {28'd0, dout0, dv0, busy0, done0}, 32'd0);
        check("reset_outs1", {28'd0, dout1, dv1, busy1, done1}, 32'd0);
        check("reset_rdy0", {31'd0, rdy0}, 32'd1);
        mon_en = 1;

        // 1: single short job with exact timing of done and start_rdy
        issue(0, 16'h000B, 4, 0);
        check("t1_first_bit", {30'd0, dv0, dout0}, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        check("t1_done_cycle5", {30'd0, done0, rdy0}, 32'd2);
        @(posedge clk);
        #1;
        check("t1_rdy_cycle6", {30'd0, done0, rdy0}, 32'd1);
        wait_idle(0);

        // 2: repeats back-to-back
        issue(0, 16'h0005, 3, 2);
        wait_idle(0);

        // 3: repeats with a gap
        issue(1, 16'h0003, 2, 1);
        wait_idle(1);

        // 4: empty job and clamped length
        issue(0, 16'hFFFF, 0, 3);
        check("t4_len0_done", {30'd0, done0, dv0}, 32'd2);
        wait_idle(0);
        issue(0, 16'hA5C3, 31, 0);
        wait_idle(0);

        // 5: reset on the third SHIFT cycle
        issue(0, 16'h00A5, 8, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        check("t5_abort_outs", {28'd0, dout0, dv0, busy0, done0}, 32'd0);
        q0.delete();
        rst = 0;
        @(posedge clk);
        #1;
        check("t5_rdy_after", {31'd0, rdy0}, 32'd1);

        // 6: loopback into a 1011 detector: bits 10110110 hit at indices 3 and 6
        hist = '0;
        hit_cnt = 0;
        first_hit = -1;
        bit_idx = 0;
        issue(0, 16'h00B6, 8, 0);
        wait_idle(0);
        check("t6_hit_count", 32'(hit_cnt), 32'd2);
        check("t6_first_hit", 32'(first_hit), 32'd3);

        // Held-valid back-to-back jobs
        issue(1, 16'h0009, 4, 1);
        issue(1, 16'h0006, 3, 0);
        wait_idle(1);

        // Randomized jobs on both instances
        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 1));
            p = 16'($urandom);
            l = int'($urandom_range(0, 20));
            r = int'($urandom_range(0, 3));
            issue(d, p, l, r);
            if ($urandom_range(0, 3) != 0) wait_idle(d);
        end
        wait_idle(0);
        wait_idle(1);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
